// File: rtl/k2p_pkg.sv
// k2p_pkg: shared types and helpers for the k2p processor.
//   state_t   run-control states (IDLE, RUN, HALTED)
//   DST_*     destination codes carried in the D field
//   get_*     field extraction from an instruction word whose payload is
//             aw bits wide. The word is passed zero-extended to FIELD_W bits.
//             Word layout, MSB first: J, C, D[1:0], payload[aw-1:0].
package k2p_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [1:0] DST_RA = 2'b00;
    localparam logic [1:0] DST_RB = 2'b01;
    localparam logic [1:0] DST_RO = 2'b10;
    localparam logic [1:0] DST_X  = 2'b11;

    localparam int FIELD_W = 32;

    function automatic logic get_j(input logic [FIELD_W-1:0] w, input int aw);
        return w[aw+3];
    endfunction

    function automatic logic get_c(input logic [FIELD_W-1:0] w, input int aw);
        return w[aw+2];
    endfunction

    function automatic logic [1:0] get_dst(input logic [FIELD_W-1:0] w, input int aw);
        return w[aw+1 -: 2];
    endfunction

    function automatic logic get_s(input logic [FIELD_W-1:0] w, input int aw);
        return w[aw-1];
    endfunction

    function automatic logic [FIELD_W-1:0] get_payload(input logic [FIELD_W-1:0] w, input int aw);
        logic [FIELD_W-1:0] mask;
        mask = (FIELD_W'(1) << aw) - FIELD_W'(1);
        return w & mask;
    endfunction

    // The immediate is the payload without its MSB (S).
    function automatic logic [FIELD_W-1:0] get_imm(input logic [FIELD_W-1:0] w, input int aw);
        logic [FIELD_W-1:0] mask;
        mask = (FIELD_W'(1) << (aw - 1)) - FIELD_W'(1);
        return w & mask;
    endfunction

endpackage

// File: rtl/k2p_alu.sv
// k2p_alu: combinational add/subtract for the k2p core.
//   a, b   operands (DATA_W)
//   sub    1 = a - b, 0 = a + b
//   sum    DATA_W-bit result
//   cout   carry out on add; borrow (b > a) on subtract
module k2p_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    logic [DATA_W:0] wide;

    // With both operands zero-extended, bit DATA_W of the difference is set
    // exactly when b > a, so the same bit serves as carry and borrow.
    always_comb begin
        if (sub) wide = {1'b0, a} - {1'b0, b};
        else     wide = {1'b0, a} + {1'b0, b};
    end

    assign sum  = wide[DATA_W-1:0];
    assign cout = wide[DATA_W];

endmodule

// File: rtl/k2p_core.sv
// k2p_core: single-cycle K2-style processor with writable program store
// and HLT/start run control.
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               leaves IDLE/HALTED into RUN (ignored in RUN)
//   prog_we/addr/wdata  program store write port, honoured outside RUN
//   result, RAout, RBout  RO, RA, RB registers
//   carry, pc           carry flag and program counter
//   busy, halted        state == RUN, state == HALTED
// Build option: define K2P_SUB_EN to make D=11 S=1 a subtract (RA <= RA-RB,
// carry <= borrow). Without it D=11 is always a NOP.
//
// state  | meaning
// IDLE   | after reset, waiting for start; program store writable
// RUN    | one instruction executed per clock
// HALTED | stopped by HLT; pc kept, program store writable, start resumes
module k2p_core
    import k2p_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int PROG_DEPTH = 16,
    localparam int ADDR_W     = $clog2(PROG_DEPTH),
    localparam int INSTR_W    = ADDR_W + 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_wdata,
    output logic [DATA_W-1:0]  result,
    output logic [DATA_W-1:0]  RAout,
    output logic [DATA_W-1:0]  RBout,
    output logic               carry,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted
);

    state_t state, state_nxt;

    logic [INSTR_W-1:0] mem [PROG_DEPTH];
    logic [INSTR_W-1:0] instr;
    logic               j, c, s, is_hlt;
    logic [1:0]         dst;
    logic [ADDR_W-1:0]  payload;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  alu_sum;
    logic               alu_cout, alu_sub;

    assign instr   = mem[pc];
    assign j       = get_j(FIELD_W'(instr), ADDR_W);
    assign c       = get_c(FIELD_W'(instr), ADDR_W);
    assign dst     = get_dst(FIELD_W'(instr), ADDR_W);
    assign s       = get_s(FIELD_W'(instr), ADDR_W);
    assign payload = ADDR_W'(get_payload(FIELD_W'(instr), ADDR_W));
    assign imm     = DATA_W'(get_imm(FIELD_W'(instr), ADDR_W));
    assign is_hlt  = !j && c;

`ifdef K2P_SUB_EN
    assign alu_sub = (dst == DST_X);
`else
    assign alu_sub = 1'b0;
`endif

    k2p_alu #(.DATA_W(DATA_W)) u_alu (
        .a    (RAout),
        .b    (RBout),
        .sub  (alu_sub),
        .sum  (alu_sum),
        .cout (alu_cout)
    );

    // Program store has no reset; reset still blocks a write on its edge.
    always_ff @(posedge clk) begin
        if (prog_we && !reset && state != RUN) mem[prog_addr] <= prog_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)  state_nxt = RUN;
            RUN:     if (is_hlt) state_nxt = HALTED;
            HALTED:  if (start)  state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            RAout  <= '0;
            RBout  <= '0;
            result <= '0;
            carry  <= 1'b0;
            pc     <= '0;
        end else if (state == RUN) begin
            pc <= pc + 1'b1;
            if (j) begin
                if (!c || carry) pc <= payload;
            end else if (!c) begin
                case (dst)
                    DST_RA: begin
                        RAout <= s ? alu_sum : imm;
                        if (s) carry <= alu_cout;
                    end
                    DST_RB: begin
                        RBout <= s ? alu_sum : imm;
                        if (s) carry <= alu_cout;
                    end
                    DST_RO: result <= RAout;
                    default: begin
`ifdef K2P_SUB_EN
                        if (s) begin
                            RAout <= alu_sum;
                            carry <= alu_cout;
                        end
`endif
                    end
                endcase
            end
        end
    end

    assign busy   = (state == RUN);
    assign halted = (state == HALTED);

endmodule

// File: tb/tb_k2p_core.sv
// Directed bench for k2p_core (DATA_W=8, PROG_DEPTH=16, 8-bit instructions).
// Encodings: {J,C,D[1:0],S,imm[2:0]}: RA<=i 0x0i, RB<=i 0x1i, RA<=RA+RB 0x08,
// RO<=RA 0x20, NOP 0x30, SUB 0x38, HLT 0x40, J a 0x8a, JC a 0xCa.
module tb_k2p_core;

    logic       clk = 1'b0;
    logic       reset, start, prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_wdata;
    logic [7:0] result, RAout, RBout;
    logic       carry, busy, halted;
    logic [3:0] pc;

    int checks = 0;
    int errors = 0;

    k2p_core dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .result     (result),
        .RAout      (RAout),
        .RBout      (RBout),
        .carry      (carry),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        prog_we    = 1'b1;
        prog_addr  = a;
        prog_wdata = d;
        tick();
        prog_we    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halt(input int budget, input string name);
        int n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL %s halt timeout: halted=%b after %0d cycles, required 1", name, halted, n);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        start      = 1'b1;
        prog_we    = $urandom_range(0, 1);
        prog_addr  = 4'($urandom_range(0, 15));
        prog_wdata = 8'($urandom_range(0, 255));
        tick();
        tick();
        checks++;
        if ({result, RAout, RBout, carry, pc} !== 29'd0) begin
            errors++;
            $display("FAIL reset_regs: RO=%0d RA=%0d RB=%0d carry=%b pc=%0d, required all 0",
                     result, RAout, RBout, carry, pc);
        end
        checks++;
        if ({busy, halted} !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: busy=%b halted=%b, required 0 0", busy, halted);
        end
        reset   = 1'b0;
        start   = 1'b0;
        prog_we = 1'b0;
        load(4'd0, 8'h30);
        load(4'd1, 8'h30);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: busy=%b, required 0", busy);
        end
        pulse_start();
        checks++;
        if (busy !== 1'b1 || pc !== 4'd0) begin
            errors++;
            $display("FAIL start_busy: busy=%b pc=%0d, required 1 0", busy, pc);
        end
        tick();
        checks++;
        if (pc !== 4'd1) begin
            errors++;
            $display("FAIL first_exec: pc=%0d, required 1", pc);
        end
        do_reset();
    endtask

    task automatic test_program();
        do_reset();
        load(4'd0, 8'h03);
        load(4'd1, 8'h15);
        load(4'd2, 8'h08);
        load(4'd3, 8'h20);
        load(4'd4, 8'h40);
        pulse_start();
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (halted !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL prog_early: halted=%b busy=%b after 4 cycles, required 0 1", halted, busy);
        end
        tick();
        checks++;
        if (result !== 8'd8 || RAout !== 8'd8 || RBout !== 8'd5 || carry !== 1'b0) begin
            errors++;
            $display("FAIL prog_regs: RO=%0d RA=%0d RB=%0d carry=%b, required 8 8 5 0",
                     result, RAout, RBout, carry);
        end
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || pc !== 4'd5) begin
            errors++;
            $display("FAIL prog_halt: halted=%b busy=%b pc=%0d, required 1 0 5", halted, busy, pc);
        end
    endtask

    task automatic load_carry_loop();
        load(4'd0, 8'h00);
        load(4'd1, 8'h17);
        load(4'd2, 8'h08);
        load(4'd3, 8'hC5);
        load(4'd4, 8'h82);
        load(4'd5, 8'h20);
        load(4'd6, 8'h40);
    endtask

    task automatic test_carry_loop();
        do_reset();
        load_carry_loop();
        pulse_start();
        wait_halt(400, "carry_loop");
        checks++;
        if (result !== 8'd3 || carry !== 1'b1 || pc !== 4'd7) begin
            errors++;
            $display("FAIL carry_loop: RO=%0d carry=%b pc=%0d, required 3 1 7", result, carry, pc);
        end
    endtask

    task automatic test_pc_wrap();
        logic [3:0] exp_pc [4];
        exp_pc = '{4'd15, 4'd0, 4'd1, 4'd2};
        do_reset();
        for (int a = 0; a < 16; a++) load(4'(a), (a == 1) ? 8'h82 : 8'h30);
        pulse_start();
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (pc !== 4'd14) begin
            errors++;
            $display("FAIL wrap_pc14: pc=%0d, required 14", pc);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (pc !== exp_pc[i]) begin
                errors++;
                $display("FAIL wrap_step%0d: pc=%0d, required %0d", i, pc, exp_pc[i]);
            end
        end
        checks++;
        if (RAout !== 8'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wrap_nop: RA=%0d busy=%b, required 0 1", RAout, busy);
        end
    endtask

    task automatic test_prog_we();
        do_reset();
        load(4'd0, 8'h01);
        load(4'd1, 8'h02);
        load(4'd2, 8'h40);
        load(4'd3, 8'h20);
        load(4'd4, 8'h40);
        pulse_start();
        prog_we    = 1'b1;
        prog_addr  = 4'd1;
        prog_wdata = 8'h05;
        tick();
        prog_we = 1'b0;
        tick();
        tick();
        checks++;
        if (RAout !== 8'd2 || halted !== 1'b1 || pc !== 4'd3) begin
            errors++;
            $display("FAIL we_in_run: RA=%0d halted=%b pc=%0d, required 2 1 3", RAout, halted, pc);
        end
        start      = 1'b1;
        prog_we    = 1'b1;
        prog_addr  = 4'd3;
        prog_wdata = 8'h05;
        tick();
        start   = 1'b0;
        prog_we = 1'b0;
        checks++;
        if (busy !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL resume: busy=%b halted=%b, required 1 0", busy, halted);
        end
        tick();
        tick();
        checks++;
        if (RAout !== 8'd5 || result !== 8'd0 || halted !== 1'b1 || pc !== 4'd5) begin
            errors++;
            $display("FAIL we_in_halt: RA=%0d RO=%0d halted=%b pc=%0d, required 5 0 1 5",
                     RAout, result, halted, pc);
        end
    endtask

    task automatic test_reset_mid_loop();
        do_reset();
        load_carry_loop();
        pulse_start();
        for (int i = 0; i < 20; i++) tick();
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        checks++;
        if ({result, RAout, RBout, carry, pc, busy, halted} !== 31'd0) begin
            errors++;
            $display("FAIL mid_reset: RO=%0d RA=%0d RB=%0d carry=%b pc=%0d busy=%b halted=%b, required all 0",
                     result, RAout, RBout, carry, pc, busy, halted);
        end
        pulse_start();
        wait_halt(400, "rerun");
        checks++;
        if (result !== 8'd3 || carry !== 1'b1) begin
            errors++;
            $display("FAIL rerun: RO=%0d carry=%b, required 3 1", result, carry);
        end
    endtask

    task automatic test_sub();
        do_reset();
        load(4'd0, 8'h02);
        load(4'd1, 8'h15);
        load(4'd2, 8'h38);
        load(4'd3, 8'h30);
        load(4'd4, 8'h40);
        pulse_start();
        wait_halt(20, "sub");
`ifdef K2P_SUB_EN
        checks++;
        if (RAout !== 8'd253 || carry !== 1'b1) begin
            errors++;
            $display("FAIL sub: RA=%0d carry=%b, required 253 1", RAout, carry);
        end
`else
        checks++;
        if (RAout !== 8'd2 || carry !== 1'b0) begin
            errors++;
            $display("FAIL sub_nop: RA=%0d carry=%b, required 2 0", RAout, carry);
        end
`endif
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_wdata = '0;
        test_reset();
        test_program();
        test_carry_loop();
        test_pc_wrap();
        test_prog_we();
        test_reset_mid_loop();
        test_sub();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
